// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity modes, line levels.
// Imported by both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned MAX_DATA_BITS = 8;
    localparam int unsigned BIT_CNT_W     = 4;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Unused data bits are already masked to zero, so they do not disturb the XOR.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input int unsigned              mode);
        logic x;
        x = ^data;
        return (mode == PAR_ODD) ? ~x : x;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding a shift stage, timed by
// an external OVERSAMPLE x baud `sample` pulse shared with the receiver.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample,
    input  logic                     tx_enable,
    input  logic [MAX_DATA_BITS-1:0] txdata,
    output logic                     tx_ready,
    output logic                     tx_busy,
    output logic                     tx
);

    localparam int unsigned SCNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    localparam logic [SCNT_W-1:0]        SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_CNT_W-1:0]     DATA_LAST = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [BIT_CNT_W-1:0]     STOP_LAST = BIT_CNT_W'(STOP_BITS - 1);
    localparam logic [MAX_DATA_BITS-1:0] DATA_MASK = MAX_DATA_BITS'((1 << DATA_BITS) - 1);
    localparam bit                       HAS_PARITY = (PARITY != PAR_NONE);

    uart_state_e              state_q, state_d;
    logic [SCNT_W-1:0]        scnt_q, scnt_d;
    logic [BIT_CNT_W-1:0]     bcnt_q, bcnt_d;
    logic [MAX_DATA_BITS-1:0] shift_q, shift_d;
    logic                     par_q, par_d;
    logic [MAX_DATA_BITS-1:0] hold_q, hold_d;
    logic                     hold_full_q, hold_full_d;
    logic                     tx_q, tx_d;
    logic                     tx_ready_q, tx_ready_d;

    logic bit_end;
    logic start_frame;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            scnt_q      <= '0;
            bcnt_q      <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_q        <= LINE_IDLE;
            tx_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            scnt_q      <= scnt_d;
            bcnt_q      <= bcnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
            tx_ready_q  <= tx_ready_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        scnt_d      = scnt_q;
        bcnt_d      = bcnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_d        = tx_q;
        start_frame = 1'b0;
        bit_end     = sample && (scnt_q == SCNT_LAST);

        // A load only happens while the holding register is empty, so it can
        // never collide with the holding-to-shifter transfer below.
        if (tx_enable && tx_ready_q) begin
            hold_d      = txdata & DATA_MASK;
            hold_full_d = 1'b1;
        end

        if (sample) begin
            if (state_q != ST_IDLE) begin
                scnt_d = bit_end ? '0 : scnt_q + 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    start_frame = hold_full_q;
                end
                ST_START: begin
                    if (bit_end) begin
                        state_d = ST_DATA;
                        bcnt_d  = '0;
                        tx_d    = shift_q[0];
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bcnt_q == DATA_LAST) begin
                            bcnt_d = '0;
                            if (HAS_PARITY) begin
                                state_d = ST_PARITY;
                                tx_d    = par_q;
                            end else begin
                                state_d = ST_STOP;
                                tx_d    = LINE_IDLE;
                            end
                        end else begin
                            bcnt_d  = bcnt_q + 1'b1;
                            shift_d = shift_q >> 1;
                            tx_d    = shift_q[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state_d = ST_STOP;
                        bcnt_d  = '0;
                        tx_d    = LINE_IDLE;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (bcnt_q == STOP_LAST) begin
                            // Back-to-back frames: a waiting byte starts on this same edge.
                            if (hold_full_q) begin
                                start_frame = 1'b1;
                            end else begin
                                state_d = ST_IDLE;
                                bcnt_d  = '0;
                                tx_d    = LINE_IDLE;
                            end
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tx_d    = LINE_IDLE;
                end
            endcase
        end

        if (start_frame) begin
            state_d     = ST_START;
            shift_d     = hold_q;
            par_d       = parity_bit(hold_q, PARITY);
            hold_full_d = 1'b0;
            scnt_d      = '0;
            bcnt_d      = '0;
            tx_d        = START_BIT;
        end

        tx_ready_d = ~hold_full_d;
    end

    assign tx       = tx_q;
    assign tx_ready = tx_ready_q;
    assign tx_busy  = (state_q != ST_IDLE) | hold_full_q;

endmodule
